// File: rtl/plp_timer_pkg.sv
// Shared definitions for the mod_timer_resp timer slave.
// Holds the register word-select encoding, CTRL/STATUS bit positions,
// the handshake FSM state encoding and an address-decode helper.
package plp_timer_pkg;

  // Word select taken from eff_addr[3:2]; byte offsets 0x0/0x4/0x8/0xC.
  typedef enum logic [1:0] {
    REG_COUNT   = 2'd0,
    REG_COMPARE = 2'd1,
    REG_CTRL    = 2'd2,
    REG_STATUS  = 2'd3
  } reg_sel_e;

  localparam int unsigned CTRL_ENABLE_BIT      = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT      = 1;
  localparam int unsigned CTRL_AUTO_RELOAD_BIT = 2;
  localparam int unsigned CTRL_PRESCALE_LSB    = 8;

  localparam int unsigned STATUS_MATCH_BIT = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } hs_state_e;

  // An access is mapped only when every address bit above the word select is zero.
  function automatic logic addr_mapped(input logic [19:0] addr);
    return addr[19:4] == '0;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick prescaler for mod_timer_resp.
// Ports:
//   clk     - system clock (rising edge)
//   rst     - asynchronous active-low reset
//   enable  - count while high; counter held at 0 while low
//   divisor - tick period minus one (tick every divisor+1 clocks)
//   clear   - restart the period from 0 (CTRL write)
//   tick    - single-cycle pulse at the end of each period
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] divisor,
  input  logic                  clear,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  // A clear restarts the period, so it also swallows a tick due that cycle.
  assign tick = enable && !clear && (cnt == divisor);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || !enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mod_timer_resp.sv
// Memory-mapped 32-bit timer with compare match and a two-state
// request/ack handshake (ack one cycle after de is sampled).
// Ports:
//   clk      - system clock (rising edge)
//   rst      - asynchronous active-low reset
//   de       - access select, held by the initiator until ack
//   we       - 1 = write, 0 = read
//   eff_addr - effective address; [3:2] select, [19:4] must be 0 to map
//   din      - write data
//   dout     - read data while ack=1, otherwise 0
//   ack      - one-cycle access-complete pulse
//   irq      - STATUS.match AND CTRL.irq_en
module mod_timer_resp
  import plp_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W    = 8,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de,
  input  logic        we,
  input  logic [19:0] eff_addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ack,
  output logic        irq
);

  hs_state_e state;

  logic [31:0]           count;
  logic [31:0]           compare;
  logic                  ctrl_enable;
  logic                  ctrl_irq_en;
  logic                  ctrl_auto_reload;
  logic [PRESCALE_W-1:0] ctrl_prescale;
  logic                  status_match;

  logic        accept;
  logic        mapped;
  reg_sel_e    sel;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_ctrl;
  logic        wr_status;
  logic        tick;
  logic        match;
  logic [31:0] ctrl_word;
  logic [31:0] rd_data;
  logic        unused_addr_bits;

  assign accept           = (state == ST_IDLE) && de;
  assign mapped           = addr_mapped(eff_addr);
  assign sel              = reg_sel_e'(eff_addr[3:2]);
  assign unused_addr_bits = ^eff_addr[1:0];

  always_comb begin
    wr_count   = 1'b0;
    wr_compare = 1'b0;
    wr_ctrl    = 1'b0;
    wr_status  = 1'b0;
    if (accept && we && mapped) begin
      case (sel)
        REG_COUNT:   wr_count   = 1'b1;
        REG_COMPARE: wr_compare = 1'b1;
        REG_CTRL:    wr_ctrl    = 1'b1;
        REG_STATUS:  wr_status  = 1'b1;
        default:     wr_count   = 1'b0;
      endcase
    end
  end

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (ctrl_enable),
    .divisor(ctrl_prescale),
    .clear  (wr_ctrl),
    .tick   (tick)
  );

  // A software COUNT write discards the tick entirely, including its match.
  assign match = tick && !wr_count && (count == compare);

  always_comb begin
    ctrl_word                                     = '0;
    ctrl_word[CTRL_ENABLE_BIT]                    = ctrl_enable;
    ctrl_word[CTRL_IRQ_EN_BIT]                    = ctrl_irq_en;
    ctrl_word[CTRL_AUTO_RELOAD_BIT]               = ctrl_auto_reload;
    ctrl_word[CTRL_PRESCALE_LSB +: PRESCALE_W]    = ctrl_prescale;
  end

  // Writes and unmapped accesses present 0 on dout.
  always_comb begin
    rd_data = '0;
    if (mapped && !we) begin
      case (sel)
        REG_COUNT:   rd_data = count;
        REG_COMPARE: rd_data = compare;
        REG_CTRL:    rd_data = ctrl_word;
        REG_STATUS:  rd_data[STATUS_MATCH_BIT] = status_match;
        default:     rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      ack   <= 1'b0;
      dout  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (de) begin
            state <= ST_ACK;
            ack   <= 1'b1;
            dout  <= rd_data;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
          ack   <= 1'b0;
          dout  <= '0;
        end
        default: begin
          state <= ST_IDLE;
          ack   <= 1'b0;
          dout  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count            <= '0;
      compare          <= RESET_COMPARE;
      ctrl_enable      <= 1'b0;
      ctrl_irq_en      <= 1'b0;
      ctrl_auto_reload <= 1'b0;
      ctrl_prescale    <= '0;
      status_match     <= 1'b0;
    end else begin
      if (wr_count) begin
        count <= din;
      end else if (tick) begin
        count <= (match && ctrl_auto_reload) ? '0 : count + 32'd1;
      end

      if (wr_compare) begin
        compare <= din;
      end

      if (wr_ctrl) begin
        ctrl_enable      <= din[CTRL_ENABLE_BIT];
        ctrl_irq_en      <= din[CTRL_IRQ_EN_BIT];
        ctrl_auto_reload <= din[CTRL_AUTO_RELOAD_BIT];
        ctrl_prescale    <= din[CTRL_PRESCALE_LSB +: PRESCALE_W];
      end

      // Hardware set takes priority over a simultaneous write-1-to-clear.
      if (match) begin
        status_match <= 1'b1;
      end else if (wr_status && din[STATUS_MATCH_BIT]) begin
        status_match <= 1'b0;
      end
    end
  end

  assign irq = status_match & ctrl_irq_en;

endmodule
